// File: rtl/seg_display_sched.sv
// rtl/seg_display_sched.sv - round-robin two-source scheduler driving a five-digit seven-segment display
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module seg_display_sched #(
  parameter int unsigned DWELL = 1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_a_i,
  input  logic [15:0] data_a_i,
  output logic        ack_a_o,
  input  logic        req_b_i,
  input  logic [15:0] data_b_i,
  output logic        ack_b_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        src_o,
  output logic [6:0]  hex0_o,
  output logic [6:0]  hex1_o,
  output logic [6:0]  hex2_o,
  output logic [6:0]  hex3_o,
  output logic [6:0]  hex4_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_LOAD = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [23:0] DWELL_LAST = 24'(DWELL - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX_RST_HI = 7'h7F;
`else
  localparam logic [6:0] HEX_RST_HI = 7'h40;
`endif
  localparam logic [34:0] HEX_RST = {HEX_RST_HI, HEX_RST_HI, HEX_RST_HI, HEX_RST_HI, 7'h40};

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        cur_q, cur_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [23:0] dwell_q, dwell_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        done_q, done_d;
  logic        src_q, src_d;
  logic [34:0] hex_q, hex_d;

  logic        grant_a, grant_b;
  logic [19:0] bcd_adj;
  logic [35:0] shifted;
  logic [4:0]  blank;
  logic [34:0] enc;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // ptr_q remembers the last granted source (1 = B), so a tie goes to the other one
  assign grant_b = req_b_i && (!req_a_i || !ptr_q);
  assign grant_a = req_a_i && !grant_b;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    blank = 5'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank[4] = (bcd_q[19:16] == 4'd0);
    blank[3] = blank[4] && (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
`endif
    enc = '0;
    for (int i = 0; i < 5; i++) begin
      enc[7*i +: 7] = blank[i] ? 7'h7F : seg7(bcd_q[4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    done_d  = 1'b0;
    src_d   = src_q;
    hex_d   = hex_q;
    case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          cur_d   = grant_b;
          ptr_d   = grant_b;
          bin_d   = grant_b ? data_b_i : data_a_i;
          bcd_d   = '0;
          cnt_d   = '0;
          ack_a_d = grant_a;
          ack_b_d = grant_b;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        {bcd_d, bin_d} = shifted;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_LOAD;
      end
      S_LOAD: begin
        hex_d   = enc;
        src_d   = cur_q;
        done_d  = 1'b1;
        dwell_d = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (dwell_q == DWELL_LAST) state_d = S_IDLE;
        else dwell_d = dwell_q + 24'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b1;
      cur_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      done_q  <= 1'b0;
      src_q   <= 1'b0;
      hex_q   <= HEX_RST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      done_q  <= done_d;
      src_q   <= src_d;
      hex_q   <= hex_d;
    end
  end

  assign ack_a_o = ack_a_q;
  assign ack_b_o = ack_b_q;
  assign done_o  = done_q;
  assign src_o   = src_q;
  assign busy_o  = (state_q != S_IDLE);
  assign hex0_o  = hex_q[6:0];
  assign hex1_o  = hex_q[13:7];
  assign hex2_o  = hex_q[20:14];
  assign hex3_o  = hex_q[27:21];
  assign hex4_o  = hex_q[34:28];

endmodule

// File: tb/tb_seg_display_sched.sv
// tb/tb_seg_display_sched.sv - scoreboard bench for seg_display_sched (DWELL = 4)
module tb_seg_display_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        ack_a, ack_b, busy, done, src;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int last_grant = -1000;
  logic [35:0] exp_q[$];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] RST_HI = 7'h7F;
`else
  localparam logic [6:0] RST_HI = 7'h40;
`endif

  seg_display_sched #(.DWELL(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_a_i(req_a), .data_a_i(data_a), .ack_a_o(ack_a),
    .req_b_i(req_b), .data_b_i(data_b), .ack_b_o(ack_b),
    .busy_o(busy), .done_o(done), .src_o(src),
    .hex0_o(hex0), .hex1_o(hex1), .hex2_o(hex2), .hex3_o(hex3), .hex4_o(hex4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    total_cnt++;
    $display("FAIL %s: timed out waiting, expected event", nm);
  endtask

  function automatic logic [6:0] seg(input int d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  // expected {src, hex4..hex0} from plain decimal division
  function automatic logic [35:0] exp_disp(input logic s, input int v);
    logic [34:0] h;
    int d [5];
    int msd = 0;
    for (int i = 0; i < 5; i++) begin
      d[i] = v % 10;
      v = v / 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < 5; i++) begin
      h[7*i +: 7] = seg(d[i]);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > msd) h[7*i +: 7] = 7'h7F;
`endif
    end
    return {s, h};
  endfunction

  // monitor: latency of each done against the last ack, and scoreboard pop
  always @(negedge clk) begin
    if (!reset) begin
      if (ack_a && ack_b) chk("dual_ack", 1, 0);
      if (ack_a || ack_b) last_grant = cyc;
      if (done) begin
        chk("latency", cyc - last_grant, 17);
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("display", {src, hex4, hex3, hex2, hex1, hex0}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ack(input logic b, output int g);
    int n = 0;
    g = -1;
    while (n < 400) begin
      @(negedge clk);
      if (b ? ack_b : ack_a) begin
        g = cyc;
        return;
      end
      n++;
    end
    timeout(b ? "ack_b" : "ack_a");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) return;
      n++;
    end
    timeout("idle");
  endtask

  task automatic send(input logic b, input logic [15:0] v);
    int g;
    @(negedge clk);
    exp_q.push_back(exp_disp(b, int'(v)));
    if (b) begin req_b = 1'b1; data_b = v; end
    else   begin req_a = 1'b1; data_a = v; end
    wait_ack(b, g);
    req_a = 1'b0; req_b = 1'b0;
    data_a = 16'hBEEF; data_b = 16'hBEEF;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int g0, g1, gsrc [4], gcyc [4], ng, n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ack_a, ack_b, done}, 0);
    chk("rst_src", src, 0);
    chk("rst_hex", {hex4, hex3, hex2, hex1, hex0}, {RST_HI, RST_HI, RST_HI, RST_HI, 7'h40});
    reset = 1'b0;

    send(1'b0, 16'd12345);
    chk("v12345_raw", {src, hex4, hex3, hex2, hex1, hex0}, {1'b0, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
    send(1'b0, 16'd65535);
    chk("v65535_raw", {hex4, hex3, hex2, hex1, hex0}, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
    send(1'b0, 16'd0);
    chk("v0_raw", {hex4, hex3, hex2, hex1, hex0}, {RST_HI, RST_HI, RST_HI, RST_HI, 7'h40});
    send(1'b1, 16'd7);
    send(1'b1, 16'd1000);
    chk("v1000_raw", {src, hex3, hex2, hex1, hex0}, {1'b1, 7'h79, 7'h40, 7'h40, 7'h40});

    // both requesters held from reset: A, B, A, B spaced 18+DWELL apart
    do_reset();
    req_a = 1'b1; data_a = 16'd111;
    req_b = 1'b1; data_b = 16'd2222;
    exp_q.push_back(exp_disp(1'b0, 111));
    exp_q.push_back(exp_disp(1'b1, 2222));
    exp_q.push_back(exp_disp(1'b0, 111));
    exp_q.push_back(exp_disp(1'b1, 2222));
    ng = 0; n = 0;
    while (ng < 4 && n < 300) begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        gsrc[ng] = ack_b ? 1 : 0;
        gcyc[ng] = cyc;
        ng++;
      end
      n++;
    end
    req_a = 1'b0; req_b = 1'b0;
    if (ng < 4) timeout("rr_grants");
    else begin
      for (int i = 0; i < 4; i++) chk("rr_order", gsrc[i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", gcyc[i] - gcyc[i-1], 22);
    end
    wait_idle();

    // req_b raised in HOLD must wait until the dwell expires
    @(negedge clk);
    req_a = 1'b1; data_a = 16'd500;
    exp_q.push_back(exp_disp(1'b0, 500));
    wait_ack(1'b0, g0);
    req_a = 1'b0;
    n = 0;
    while (cyc < g0 + 19 && n < 100) begin @(negedge clk); n++; end
    req_b = 1'b1; data_b = 16'd42;
    exp_q.push_back(exp_disp(1'b1, 42));
    wait_ack(1'b1, g1);
    req_b = 1'b0;
    chk("hold_ack_b", g1 - g0, 22);
    wait_idle();

    // reset in the middle of a conversion, then a fresh regrant
    @(negedge clk);
    req_a = 1'b1; data_a = 16'd4321;
    wait_ack(1'b0, g0);
    n = 0;
    while (cyc < g0 + 7 && n < 100) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_src", src, 0);
    chk("abort_hex", {hex4, hex3, hex2, hex1, hex0}, {RST_HI, RST_HI, RST_HI, RST_HI, 7'h40});
    reset = 1'b0;
    exp_q.push_back(exp_disp(1'b0, 4321));
    wait_ack(1'b0, g1);
    req_a = 1'b0;
    wait_idle();

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seg_display_sched.md
# seg_display_sched

Sequential scheduler for the board's five-digit seven-segment display. Arbitrates two 16-bit value sources (port A: ADC sample path, port B: UART-side counter) with round-robin req/ack handshakes, converts the granted value to decimal by a 16-cycle iterative double-dabble, and registers active-low segment codes onto the HEX outputs. Each result is held for a programmable dwell time before the next grant.

## Interface
- DWELL, default 1000: cycles a result is held before a new grant is allowed; legal range 1..2^24-1.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_a  in  1  level request from source A; held with data_a stable until ack_a.
- data_a  in  16  unsigned value from source A.
- ack_a  out  1  one-cycle pulse; data_a captured.
- req_b  in  1  as req_a, source B.
- data_b  in  16  unsigned value from source B.
- ack_b  out  1  as ack_a, source B.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when new segment codes appear.
- src  out  1  source of the displayed value (0 = A, 1 = B).
- hex0..hex4  out  7 each  active-low segments; bit0 = a … bit6 = g; hex0 = units.

## Operation
- FSM states: IDLE, CONV, LOAD, HOLD.
- IDLE: if req_a or req_b is high at an edge, grant one source, capture its data into the binary shift register, clear the BCD register (20 bits), set bit count to 0, pulse the matching ack, go to CONV. With neither request, stay.
- Arbitration: round-robin on last-granted pointer. If both request, grant the source not granted last. Reset sets pointer = B, so A wins the first tie. A single requester is always granted.
- CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. After 16 shifts, go to LOAD.
- LOAD: encode the 5 BCD nibbles, register hex0..hex4, update src, pulse done, clear dwell counter, go to HOLD.
- HOLD: increment the dwell counter; on reaching DWELL-1, go to IDLE. Requests are ignored in HOLD.
- Segment codes, in hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F. Nibbles > 9 cannot occur.
- Requesters hold req until ack. A req dropped before grant is not serviced. data is sampled only at the grant edge.
- Reset, including mid-CONV/HOLD: state IDLE, ack_a = ack_b = done = busy = 0, src = 0, pointer = B, hex0 = 40, hex1..hex4 = 40 (or 7F when blanking is compiled in). An aborted conversion produces no done.

## Timing
- Grant edge G: ack high during cycle G..G+1; busy high from G+1.
- Conversion shifts occur on edges G+1..G+16. LOAD at edge G+17: hex/src updated and done high for cycle G+17..G+18.
- HOLD occupies DWELL cycles. Earliest next grant edge is G+18+DWELL. busy falls at edge G+17+DWELL.
- Grant-to-display latency is 17 cycles. Throughput is one value per 18+DWELL cycles.
- ack and done never overlap for the same conversion. At most one ack per cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digits above the most significant nonzero digit show 7F. hex0 always shows its digit, so the value 0 displays as a single "0".
- Not defined: all five digits are always driven, including leading zeros (40).

## Test plan
- After reset, req_a=1, data_a=12345 at edge G: ack_a pulse at G; at G+17, hex4..hex0 = 79,24,30,19,12, src=0, done pulse.
- data_a=65535: hex4..hex0 = 02,12,12,30,12. data_a=0: hex0=40, hex1..4 = 7F with LEADING_ZERO_BLANK_EN, 40 without.
- req_a and req_b both held from reset, DWELL=4: grants in order A, B, A, B. Grant edges are spaced 22 cycles apart. src alternates 0,1,0,1.
- DWELL=4, req_b rises during HOLD: ack_b is not before edge G+22, and occurs exactly at G+22.
- Reset asserted at 8th CONV cycle: next cycle busy=0, no done, hex at reset values. A held req_a is then regranted with a fresh 17-cycle latency.
- data_b=7 with blanking: hex0=78, hex1..4=7F. data_b=1000: hex3..hex0 = 79,40,40,40, hex4=7F.
